// File: rtl/weight_update_ctrl_if.sv
// -----------------------------------------------------------------------------
// weight_update_ctrl_if
//
// Purpose:
//   Bundles the delta handshake (error/delta datapath -> controller) and the
//   shared weight bus (controller -> weight register bank) used by
//   weight_update_ctrl.
//
// Signals:
//   dw_in          [31:0]      delta for the weight currently awaited
//   dw_valid                   dw_in is valid
//   dw_ready                   controller accepts a delta this cycle
//   dw_out         [31:0]      registered delta on the shared weight bus
//   select_initial             broadcast initial-load strobe
//   select_update  [NUM_W-1:0] one-hot per-weight update strobe
//
// Modports:
//   master : delta producer / weight-bank side (drives dw_in, dw_valid)
//   slave  : the controller (drives handshake ready and the weight bus)
// -----------------------------------------------------------------------------
interface weight_update_ctrl_if #(
  parameter int NUM_W = 4
);
  logic [31:0]      dw_in;
  logic             dw_valid;
  logic             dw_ready;
  logic [31:0]      dw_out;
  logic             select_initial;
  logic [NUM_W-1:0] select_update;

  modport master (
    output dw_in,
    output dw_valid,
    input  dw_ready,
    input  dw_out,
    input  select_initial,
    input  select_update
  );

  modport slave (
    input  dw_in,
    input  dw_valid,
    output dw_ready,
    output dw_out,
    output select_initial,
    output select_update
  );
endinterface

// File: rtl/weight_update_ctrl.sv
// -----------------------------------------------------------------------------
// weight_update_ctrl
//
// Purpose:
//   Sequencer for a bank of NUM_W backprop weight registers sharing one 32-bit
//   delta bus. Issues the broadcast initial-load strobe, serialises incoming
//   deltas into one-hot update strobes (weight 0 .. NUM_W-1, repeated once per
//   training sample) and pulses done when all samples have been applied.
//
// Parameters:
//   NUM_W  number of weight registers served (>= 2)
//   IDX_W  width of the weight index, clog2(NUM_W)
//   SMP_W  width of the sample counter and of num_samples
//
// Ports:
//   clk          single clock, rising edge
//   reset        asynchronous, active-low reset
//   init_req     one-cycle request to load initial values into all weights
//   train_start  one-cycle request to start a training run
//   num_samples  samples in the run, captured on train_start
//   abort        synchronous return to IDLE, highest priority input
//   bus          weight_update_ctrl_if.slave: dw_in/dw_valid/dw_ready handshake
//                plus dw_out/select_initial/select_update weight bus
//   cur_idx      index of the weight awaiting (or receiving) its delta
//   busy         controller is not in IDLE
//   done         one-cycle run-complete pulse
//
// Build option:
//   WUC_SKIP_ZERO_EN  when defined, an accepted delta of 32'h0 still advances
//                     the sequence but its update strobe is withheld (the
//                     weight would not change anyway). Cycle timing is the
//                     same in both builds.
// -----------------------------------------------------------------------------
module weight_update_ctrl #(
  parameter int NUM_W = 4,
  parameter int IDX_W = 2,
  parameter int SMP_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init_req,
  input  logic                 train_start,
  input  logic [SMP_W-1:0]     num_samples,
  input  logic                 abort,
  weight_update_ctrl_if.slave  bus,
  output logic [IDX_W-1:0]     cur_idx,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_WAIT_DW,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg,   idx_next;
  logic [SMP_W-1:0] smp_reg,   smp_next;
  logic [SMP_W-1:0] n_lat_reg, n_lat_next;
  logic [31:0]      dw_out_reg, dw_out_next;

  logic             last_w;
  logic [SMP_W-1:0] smp_inc;
  logic             strobe_en;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= S_IDLE;
      idx_reg    <= '0;
      smp_reg    <= '0;
      n_lat_reg  <= '0;
      dw_out_reg <= '0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      smp_reg    <= smp_next;
      n_lat_reg  <= n_lat_next;
      dw_out_reg <= dw_out_next;
    end
  end

  assign last_w  = (idx_reg == IDX_W'(NUM_W - 1));
  // smp never reaches 2^SMP_W-1 before DONE, so this increment cannot wrap
  // on any path that uses it.
  assign smp_inc = smp_reg + 1'b1;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    smp_next    = smp_reg;
    n_lat_next  = n_lat_reg;
    dw_out_next = dw_out_reg;

    if (abort) begin
      // abort outranks everything, including requests seen in IDLE.
      state_next = S_IDLE;
      idx_next   = '0;
      smp_next   = '0;
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          if (init_req) begin
            // A simultaneous train_start is intentionally dropped.
            state_next = S_INIT;
          end else if (train_start) begin
            n_lat_next = num_samples;
            idx_next   = '0;
            smp_next   = '0;
            state_next = (num_samples == '0) ? S_DONE : S_WAIT_DW;
          end
        end

        S_INIT: begin
          state_next = S_IDLE;
        end

        S_WAIT_DW: begin
          if (bus.dw_valid) begin
            dw_out_next = bus.dw_in;
            state_next  = S_UPDATE;
          end
        end

        S_UPDATE: begin
          if (last_w) begin
            idx_next   = '0;
            smp_next   = smp_inc;
            state_next = (smp_inc == n_lat_reg) ? S_DONE : S_WAIT_DW;
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = S_WAIT_DW;
          end
        end

        S_DONE: begin
          state_next = S_IDLE;
        end

        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from registered state. abort is the only input allowed
  // to reach them combinationally: it masks the strobes and the ready so that
  // nothing is issued or handshaken in the cycle that is being cancelled.
  // ---------------------------------------------------------------------------
`ifdef WUC_SKIP_ZERO_EN
  // A zero delta leaves the weight unchanged, so its strobe is withheld.
  assign strobe_en = (state_reg == S_UPDATE) && !abort && (dw_out_reg != 32'h0);
`else
  assign strobe_en = (state_reg == S_UPDATE) && !abort;
`endif

  generate
    for (genvar gi = 0; gi < NUM_W; gi++) begin : g_sel
      assign bus.select_update[gi] = strobe_en && (idx_reg == IDX_W'(gi));
    end
  endgenerate

  assign bus.select_initial = (state_reg == S_INIT) && !abort;
  assign bus.dw_ready       = (state_reg == S_WAIT_DW) && !abort;
  assign bus.dw_out         = dw_out_reg;
  assign cur_idx            = idx_reg;
  assign busy               = (state_reg != S_IDLE);
  assign done               = (state_reg == S_DONE);

endmodule

// File: tb/tb_weight_update_ctrl.sv
module tb_weight_update_ctrl;
  localparam int NUM_W = 4;
  localparam int IDX_W = 2;
  localparam int SMP_W = 16;
`ifdef WUC_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             init_req, train_start, abort;
  logic [SMP_W-1:0] num_samples;
  logic [IDX_W-1:0] cur_idx;
  logic             busy, done;

  weight_update_ctrl_if #(.NUM_W(NUM_W)) bus_if ();

  weight_update_ctrl #(.NUM_W(NUM_W), .IDX_W(IDX_W), .SMP_W(SMP_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .init_req    (init_req),
    .train_start (train_start),
    .num_samples (num_samples),
    .abort       (abort),
    .bus         (bus_if),
    .cur_idx     (cur_idx),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: tracks which kind of cycle the controller is in and how
  // many deltas of the run have been accepted; weight index = accepted mod NUM_W.
  bit          m_init, m_done, m_strobe, m_wait;
  int          m_acc, m_total;
  logic [31:0] m_dw;

  // Actual outputs captured mid-cycle by cyc().
  logic             a_busy, a_rdy, a_si, a_done;
  logic [NUM_W-1:0] a_su;
  logic [IDX_W-1:0] a_idx;
  logic [31:0]      a_dw;

  typedef struct {
    logic             ir, ts, ab, v;
    logic [31:0]      d;
    logic [SMP_W-1:0] ns;
    logic             e_busy, e_si, e_rdy, e_done;
    logic [NUM_W-1:0] e_su;
    logic [IDX_W-1:0] e_idx;
    logic [31:0]      e_dw;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_init = 0; m_done = 0; m_strobe = 0; m_wait = 0;
    m_acc = 0; m_total = 0; m_dw = '0;
  endtask

  function automatic bit model_busy();
    return m_init || m_done || m_strobe || m_wait;
  endfunction

  // One clock cycle: inputs applied just after a rising edge, outputs checked
  // at the falling edge against the model, then the model advances.
  task automatic cyc(input logic ir, input logic ts, input logic ab, input logic v,
                     input logic [31:0] d, input logic [SMP_W-1:0] ns);
    logic             e_busy, e_rdy, e_si, e_done;
    logic [NUM_W-1:0] e_su;
    int               e_idx;
    init_req = ir; train_start = ts; abort = ab;
    bus_if.dw_valid = v; bus_if.dw_in = d; num_samples = ns;
    @(negedge clk);
    e_busy = model_busy();
    e_rdy  = m_wait && !ab;
    e_si   = m_init && !ab;
    e_done = m_done;
    e_su   = '0;
    if (m_strobe && !ab && !(SKIP && m_dw == 32'h0)) e_su[(m_acc - 1) % NUM_W] = 1'b1;
    e_idx = m_wait ? (m_acc % NUM_W) : (m_strobe ? ((m_acc - 1) % NUM_W) : 0);

    a_busy = busy; a_rdy = bus_if.dw_ready; a_si = bus_if.select_initial;
    a_done = done; a_su = bus_if.select_update; a_idx = cur_idx; a_dw = bus_if.dw_out;

    chk("m_busy", a_busy, e_busy);
    chk("m_dw_ready", a_rdy, e_rdy);
    chk("m_sel_init", a_si, e_si);
    chk("m_done", a_done, e_done);
    chk("m_sel_upd", a_su, e_su);
    chk("m_cur_idx", a_idx, e_idx);
    chk("m_dw_out", a_dw, m_dw);
    chk("m_onehot", $countones(a_su) <= 1 && !(a_si && a_su != 0), 1);

    if (ab) begin
      m_init = 0; m_done = 0; m_strobe = 0; m_wait = 0; m_acc = 0;
    end else if (m_wait) begin
      if (v) begin m_dw = d; m_acc++; m_wait = 0; m_strobe = 1; end
    end else if (m_strobe) begin
      m_strobe = 0;
      if (m_acc == m_total) m_done = 1; else m_wait = 1;
    end else if (m_init || m_done) begin
      m_init = 0; m_done = 0;
    end else if (ir) begin
      m_init = 1;
    end else if (ts) begin
      m_total = int'(ns) * NUM_W; m_acc = 0;
      if (ns == 0) m_done = 1; else m_wait = 1;
    end
    @(posedge clk); #1;
  endtask

  // Finish any run in progress with continuous valid deltas (bounded).
  task automatic drain();
    int n = 0;
    while (model_busy() && n < 200) begin
      cyc(0, 0, 0, 1, $urandom, 0);
      n++;
    end
    chk("drain_bound", (n >= 200) ? 1 : 0, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rdy"}, bus_if.dw_ready, 0);
    chk({tag, "_si"}, bus_if.select_initial, 0);
    chk({tag, "_su"}, bus_if.select_update, 0);
    chk({tag, "_idx"}, cur_idx, 0);
    chk({tag, "_dw"}, bus_if.dw_out, 0);
  endtask

  initial begin
    logic [NUM_W-1:0] req_su;
    int nstrobe;

    //        ir ts ab v  d   ns | busy si rdy done su       idx dw
    vecs[0]  = '{0,0,0,0, 0,  0,  0,0,0,0, 4'b0000, 0, 0};
    vecs[1]  = '{1,0,0,0, 0,  0,  0,0,0,0, 4'b0000, 0, 0};   // init_req sampled
    vecs[2]  = '{0,0,0,0, 0,  0,  1,1,0,0, 4'b0000, 0, 0};   // INIT cycle
    vecs[3]  = '{0,0,0,0, 0,  0,  0,0,0,0, 4'b0000, 0, 0};
    vecs[4]  = '{0,1,0,0, 0,  0,  0,0,0,0, 4'b0000, 0, 0};   // num_samples=0
    vecs[5]  = '{0,0,0,0, 0,  0,  1,0,0,1, 4'b0000, 0, 0};   // straight to DONE
    vecs[6]  = '{0,0,0,0, 0,  0,  0,0,0,0, 4'b0000, 0, 0};
    vecs[7]  = '{1,1,0,0, 0,  3,  0,0,0,0, 4'b0000, 0, 0};   // both requests
    vecs[8]  = '{0,0,0,0, 0,  0,  1,1,0,0, 4'b0000, 0, 0};   // INIT only
    vecs[9]  = '{0,0,0,0, 0,  0,  0,0,0,0, 4'b0000, 0, 0};   // train dropped
    vecs[10] = '{0,1,0,0, 0,  1,  0,0,0,0, 4'b0000, 0, 0};
    vecs[11] = '{0,0,0,0, 0,  0,  1,0,1,0, 4'b0000, 0, 0};
    vecs[12] = '{0,0,0,1, 5,  0,  1,0,1,0, 4'b0000, 0, 0};   // accept 5
    vecs[13] = '{0,0,0,0, 0,  0,  1,0,0,0, 4'b0001, 0, 5};
    vecs[14] = '{0,0,0,1, 6,  0,  1,0,1,0, 4'b0000, 1, 5};   // accept 6
    vecs[15] = '{0,0,1,0, 0,  0,  1,0,0,0, 4'b0000, 1, 6};   // abort in UPDATE
    vecs[16] = '{0,0,0,0, 0,  0,  0,0,0,0, 4'b0000, 0, 6};
    vecs[17] = '{0,1,0,0, 0,  1,  0,0,0,0, 4'b0000, 0, 6};
    vecs[18] = '{0,0,0,0, 0,  0,  1,0,1,0, 4'b0000, 0, 6};
    vecs[19] = '{0,0,1,1, 9,  0,  1,0,0,0, 4'b0000, 0, 6};   // abort in WAIT_DW
    vecs[20] = '{0,0,0,0, 0,  0,  0,0,0,0, 4'b0000, 0, 6};

    // Reset state
    reset = 1'b0; init_req = 0; train_start = 0; abort = 0;
    num_samples = '0; bus_if.dw_valid = 0; bus_if.dw_in = '0;
    model_reset();
    #1;
    chk_all_zero("rst");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      cyc(vecs[i].ir, vecs[i].ts, vecs[i].ab, vecs[i].v, vecs[i].d, vecs[i].ns);
      chk($sformatf("v%0d_busy", i), a_busy, vecs[i].e_busy);
      chk($sformatf("v%0d_si", i), a_si, vecs[i].e_si);
      chk($sformatf("v%0d_rdy", i), a_rdy, vecs[i].e_rdy);
      chk($sformatf("v%0d_done", i), a_done, vecs[i].e_done);
      chk($sformatf("v%0d_su", i), a_su, vecs[i].e_su);
      chk($sformatf("v%0d_idx", i), a_idx, vecs[i].e_idx);
      chk($sformatf("v%0d_dw", i), a_dw, vecs[i].e_dw);
    end

    // Full run: 2 samples, continuous valid, incrementing deltas
    cyc(0, 1, 0, 0, 0, 2);
    chk("run_c0_done", a_done, 0);
    nstrobe = 0;
    for (int j = 1; j <= 19; j++) begin
      cyc(0, 0, 0, 1, 32'h00F0_0000 + m_acc, 0);
      req_su = '0;
      if (j % 2 == 0 && j <= 16) req_su[(j / 2 - 1) % NUM_W] = 1'b1;
      chk($sformatf("run_c%0d_su", j), a_su, req_su);
      chk($sformatf("run_c%0d_done", j), a_done, (j == 17) ? 1 : 0);
      if (j % 2 == 0 && j <= 16)
        chk($sformatf("run_c%0d_dw", j), a_dw, 32'h00F0_0000 + j / 2 - 1);
      if (a_su != 0) nstrobe++;
    end
    chk("run_strobes", nstrobe, 8);

    // Back-pressure at idx 1
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 32'h11, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("bp_first_su", a_su, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 0, 32'hDEAD, 0);
      chk($sformatf("bp%0d_rdy", k), a_rdy, 1);
      chk($sformatf("bp%0d_su", k), a_su, 0);
      chk($sformatf("bp%0d_idx", k), a_idx, 1);
    end
    cyc(0, 0, 0, 1, 32'h22, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("bp_resume_su", a_su, 4'b0010);
    chk("bp_resume_dw", a_dw, 32'h22);
    drain();

    // Abort during UPDATE at idx 2
    cyc(0, 1, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 1, 32'h100 + k, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("ab_su", a_su, 0);
    chk("ab_idx", a_idx, 2);
    cyc(0, 0, 0, 0, 0, 0);
    chk("ab_busy", a_busy, 0);
    chk("ab_idx0", a_idx, 0);
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 32'h77, 0);
    chk("ab_restart_idx", a_idx, 0);
    drain();

    // Zero delta for weight 1
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 32'h7, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("sz_su", a_su, SKIP ? 4'b0000 : 4'b0010);
    chk("sz_idx_upd", a_idx, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("sz_idx_next", a_idx, 2);
    drain();

    // Reset mid-run
    cyc(0, 1, 0, 0, 0, 2);
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 1, 32'h300 + k, 0);
    init_req = 0; train_start = 0; abort = 0; bus_if.dw_valid = 1;
    #2 reset = 1'b0;
    #1 chk_all_zero("mrst");
    @(posedge clk); #1;
    chk_all_zero("mrst_hold");
    model_reset();
    reset = 1'b1;

    // Randomised traffic against the model
    for (int k = 0; k < 2500; k++) begin
      cyc(($urandom % 40) == 0, ($urandom % 6) == 0, ($urandom % 60) == 0,
          $urandom % 2, (($urandom % 4) == 0) ? 32'h0 : $urandom,
          SMP_W'($urandom_range(0, 3)));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
